transpose_skew_buffer: RTL and testbench

//  Double-buffered DIMxDIM tile buffer feeding the systolic array edge. Accepts one row
//  per cycle (valid/ready) into a ping-pong bank. Drains a full bank as DIM parallel lanes,

---
 rtl/transpose_skew_buffer_if.sv | 27 ++
 rtl/transpose_skew_buffer.sv | 160 ++++++++++++++++
 tb/tb_transpose_skew_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/transpose_skew_buffer_if.sv
// Row-load and lane-drain bus of the transpose/skew tile buffer.
// master = loader/consumer side, slave = the buffer itself.
interface transpose_skew_buffer_if #(
    parameter int DIM  = 8,
    parameter int BITS = 8
);
    logic                      clr;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [DIM-1:0][BITS-1:0]  wr_data;
    logic                      mode;
    logic                      en;
    logic [DIM-1:0][BITS-1:0]  Aout;
    logic                      out_valid;
    logic                      tile_done;
    logic                      busy;

    modport master (
        output clr, wr_valid, wr_data, mode, en,
        input  wr_ready, Aout, out_valid, tile_done, busy
    );

    modport slave (
        input  clr, wr_valid, wr_data, mode, en,
        output wr_ready, Aout, out_valid, tile_done, busy
    );
endinterface

// File: rtl/transpose_skew_buffer.sv
// Ping-pong DIMxDIM tile buffer: rows written into one bank while the other bank
// drains as DIM parallel lanes, optionally transposed and diagonally skewed.
module transpose_skew_buffer #(
    parameter int DIM  = 8,
    parameter int BITS = 8,
    parameter int SKEW = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    transpose_skew_buffer_if.slave bus
);
    localparam int LAST = (SKEW != 0) ? 2*DIM-2 : DIM-1;
    localparam int SW   = $clog2(LAST+2);
    localparam int IW   = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [BITS-1:0]          bank_reg [2][DIM][DIM];
    logic [1:0]               full_reg;
    logic                     wr_bank_reg;
    logic                     rd_bank_reg;
    logic [IW-1:0]            wr_idx_reg;
    logic [SW-1:0]            step_reg;
    logic                     mode_reg;
    state_t                   state_reg;
    logic [DIM-1:0][BITS-1:0] aout_reg;
    logic                     out_valid_reg;
    logic                     tile_done_reg;
    logic                     busy_reg;

    logic                     wr_fire;
    logic                     drain_fire;
    logic                     last_step;
    logic [1:0]               full_set;
    logic [1:0]               full_clr;
    logic [DIM-1:0][BITS-1:0] lane_next;

    assign wr_fire    = bus.wr_valid && !full_reg[wr_bank_reg];
    assign drain_fire = (state_reg == DRAIN) && bus.en;
    assign last_step  = (step_reg == SW'(LAST));
    assign full_set   = (wr_fire && wr_idx_reg == IW'(DIM-1)) ? (2'b01 << wr_bank_reg) : 2'b00;
    assign full_clr   = (drain_fire && last_step) ? (2'b01 << rd_bank_reg) : 2'b00;

    // Each lane picks its element from the draining bank; k outside the tile pads with zero.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        int              k;
        logic [IW-1:0]   kidx;
        logic [BITS-1:0] elem;
        always_comb begin
            k    = (SKEW != 0) ? int'(step_reg) - gi : int'(step_reg);
            kidx = k[IW-1:0];
            elem = '0;
            if (k >= 0 && k < DIM) begin
                elem = mode_reg ? bank_reg[rd_bank_reg][kidx][gi]
                                : bank_reg[rd_bank_reg][gi][kidx];
            end
        end
        assign lane_next[gi] = elem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++)
                        bank_reg[b][r][c] <= '0;
        end else if (bus.clr) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++)
                        bank_reg[b][r][c] <= '0;
        end else if (wr_fire) begin
            for (int c = 0; c < DIM; c++)
                bank_reg[wr_bank_reg][wr_idx_reg][c] <= bus.wr_data[DIM-1-c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg      <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_idx_reg    <= '0;
            step_reg      <= '0;
            mode_reg      <= 1'b0;
            state_reg     <= IDLE;
            aout_reg      <= '0;
            out_valid_reg <= 1'b0;
            tile_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (bus.clr) begin
            full_reg      <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_idx_reg    <= '0;
            step_reg      <= '0;
            mode_reg      <= 1'b0;
            state_reg     <= IDLE;
            aout_reg      <= '0;
            out_valid_reg <= 1'b0;
            tile_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            // Set and clear always hit different banks, so both apply.
            full_reg <= (full_reg & ~full_clr) | full_set;

            if (wr_fire) begin
                if (wr_idx_reg == IW'(DIM-1)) begin
                    wr_idx_reg  <= '0;
                    wr_bank_reg <= ~wr_bank_reg;
                end else begin
                    wr_idx_reg <= wr_idx_reg + 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    out_valid_reg <= 1'b0;
                    tile_done_reg <= 1'b0;
                    if (full_reg[rd_bank_reg]) begin
                        mode_reg  <= bus.mode;
                        step_reg  <= '0;
                        state_reg <= DRAIN;
                        busy_reg  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.en) begin
                        aout_reg      <= lane_next;
                        out_valid_reg <= 1'b1;
                        if (last_step) begin
                            tile_done_reg <= 1'b1;
                            rd_bank_reg   <= ~rd_bank_reg;
                            if (full_reg[~rd_bank_reg]) begin
                                step_reg <= '0;
                                mode_reg <= bus.mode;
                            end else begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            step_reg      <= step_reg + 1'b1;
                            tile_done_reg <= 1'b0;
                        end
                    end else begin
                        out_valid_reg <= 1'b0;
                        tile_done_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready  = !full_reg[wr_bank_reg];
    assign bus.Aout      = aout_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.tile_done = tile_done_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_transpose_skew_buffer.sv
// Directed bench for transpose_skew_buffer: skewed instance (a) and unskewed instance (b), DIM=4.
module tb_transpose_skew_buffer;
    localparam int DIM  = 4;
    localparam int BITS = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   nvalid;

    transpose_skew_buffer_if #(.DIM(DIM), .BITS(BITS)) ifa ();
    transpose_skew_buffer_if #(.DIM(DIM), .BITS(BITS)) ifb ();

    transpose_skew_buffer #(.DIM(DIM), .BITS(BITS), .SKEW(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    transpose_skew_buffer #(.DIM(DIM), .BITS(BITS), .SKEW(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Row r of a tile with A[r][c] = base + 16*r + c; column 0 sits at the top index.
    function automatic logic [31:0] row_word(input int base, input int r);
        logic [31:0] v;
        for (int c = 0; c < DIM; c++) v[(DIM-1-c)*BITS +: BITS] = 8'(base + 16*r + c);
        return v;
    endfunction

    // Expected lanes at drain step s: k = skew ? s-i : s, zero outside the tile.
    function automatic logic [31:0] exp_aout(input int base, input bit mode, input bit skew, input int s);
        logic [31:0] v;
        int k;
        v = '0;
        for (int i = 0; i < DIM; i++) begin
            k = skew ? s - i : s;
            if (k >= 0 && k < DIM)
                v[i*BITS +: BITS] = mode ? 8'(base + 16*k + i) : 8'(base + 16*i + k);
        end
        return v;
    endfunction

    task automatic load_a(input int base);
        for (int r = 0; r < DIM; r++) begin
            ifa.wr_valid = 1'b1;
            ifa.wr_data  = row_word(base, r);
            tick();
        end
        ifa.wr_valid = 1'b0;
    endtask

    task automatic load_b(input int base);
        for (int r = 0; r < DIM; r++) begin
            ifb.wr_valid = 1'b1;
            ifb.wr_data  = row_word(base, r);
            tick();
        end
        ifb.wr_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ifa.clr = 1'b0; ifa.wr_valid = 1'b0; ifa.wr_data = '0; ifa.mode = 1'b0; ifa.en = 1'b1;
        ifb.clr = 1'b0; ifb.wr_valid = 1'b0; ifb.wr_data = '0; ifb.mode = 1'b0; ifb.en = 1'b1;

        // Reset state
        #2;
        check("rst_aout", ifa.Aout, 32'h0);
        check("rst_out_valid", ifa.out_valid, 1'b0);
        check("rst_busy", ifa.busy, 1'b0);
        check("rst_tile_done", ifa.tile_done, 1'b0);
        check("rst_wr_ready", ifa.wr_ready, 1'b1);
        #10 rst_n = 1'b1;
        tick();

        // Skewed, untransposed drain
        ifa.mode = 1'b0;
        load_a(0);
        check("t2_busy_before_start", ifa.busy, 1'b0);
        check("t2_wr_ready_other_bank", ifa.wr_ready, 1'b1);
        tick();
        check("t2_busy", ifa.busy, 1'b1);
        check("t2_no_valid_yet", ifa.out_valid, 1'b0);
        for (int s = 0; s <= 6; s++) begin
            tick();
            check($sformatf("t2_valid_s%0d", s), ifa.out_valid, 1'b1);
            check($sformatf("t2_aout_s%0d", s), ifa.Aout, exp_aout(0, 1'b0, 1'b1, s));
            check($sformatf("t2_done_s%0d", s), ifa.tile_done, (s == 6) ? 1'b1 : 1'b0);
            if (s == 0) check("t2_step0_literal", ifa.Aout, 32'h0000_0000);
            if (s == 1) check("t2_step1_literal", ifa.Aout, 32'h0000_1001);
            if (s == 6) check("t2_step6_literal", ifa.Aout, 32'h3300_0000);
        end
        tick();
        check("t2_idle_valid", ifa.out_valid, 1'b0);
        check("t2_idle_busy", ifa.busy, 1'b0);
        check("t2_idle_done", ifa.tile_done, 1'b0);
        check("t2_idle_hold", ifa.Aout, 32'h3300_0000);

        // Skewed, transposed drain; mode flips mid-tile and must not matter
        ifa.mode = 1'b1;
        load_a(0);
        tick();
        check("t3_busy", ifa.busy, 1'b1);
        ifa.mode = 1'b0;
        nvalid = 0;
        for (int s = 0; s <= 8; s++) begin
            tick();
            if (ifa.out_valid === 1'b1) nvalid++;
            if (s <= 6) begin
                check($sformatf("t3_aout_s%0d", s), ifa.Aout, exp_aout(0, 1'b1, 1'b1, s));
                check($sformatf("t3_done_s%0d", s), ifa.tile_done, (s == 6) ? 1'b1 : 1'b0);
            end
            if (s == 1) check("t3_step1_lane1", ifa.Aout[1], 8'h01);
        end
        check("t3_valid_count", nvalid, 7);

        // Stall with en low for 3 cycles after step 2
        ifa.mode = 1'b0;
        load_a(0);
        tick();
        for (int s = 0; s <= 2; s++) begin
            tick();
            check($sformatf("t5_aout_s%0d", s), ifa.Aout, exp_aout(0, 1'b0, 1'b1, s));
        end
        ifa.en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check($sformatf("t5_stall_valid_%0d", n), ifa.out_valid, 1'b0);
            check($sformatf("t5_stall_hold_%0d", n), ifa.Aout, exp_aout(0, 1'b0, 1'b1, 2));
            check($sformatf("t5_stall_busy_%0d", n), ifa.busy, 1'b1);
        end
        ifa.en = 1'b1;
        for (int s = 3; s <= 6; s++) begin
            tick();
            check($sformatf("t5_valid_s%0d", s), ifa.out_valid, 1'b1);
            check($sformatf("t5_aout_s%0d", s), ifa.Aout, exp_aout(0, 1'b0, 1'b1, s));
            check($sformatf("t5_done_s%0d", s), ifa.tile_done, (s == 6) ? 1'b1 : 1'b0);
        end
        tick();

        // Ping-pong: tile A (base 0), tile B (base 0x80) back to back, then a stalled row of tile C
        for (int cyc = 1; cyc <= 15; cyc++) begin
            ifa.wr_valid = (cyc <= 13);
            if (cyc <= 4)      ifa.wr_data = row_word(0, cyc - 1);
            else if (cyc <= 8) ifa.wr_data = row_word(8'h80, cyc - 5);
            else               ifa.wr_data = row_word(8'h40, 0);
            tick();
            check($sformatf("t4_wr_ready_c%0d", cyc), ifa.wr_ready, (cyc >= 8 && cyc <= 11) ? 1'b0 : 1'b1);
            check($sformatf("t4_valid_c%0d", cyc), ifa.out_valid, (cyc >= 6) ? 1'b1 : 1'b0);
            check($sformatf("t4_busy_c%0d", cyc), ifa.busy, (cyc >= 5) ? 1'b1 : 1'b0);
            check($sformatf("t4_done_c%0d", cyc), ifa.tile_done, (cyc == 12) ? 1'b1 : 1'b0);
            if (cyc >= 6 && cyc <= 12)
                check($sformatf("t4_aoutA_c%0d", cyc), ifa.Aout, exp_aout(0, 1'b0, 1'b1, cyc - 6));
            if (cyc >= 13)
                check($sformatf("t4_aoutB_c%0d", cyc), ifa.Aout, exp_aout(8'h80, 1'b0, 1'b1, cyc - 13));
        end
        ifa.wr_valid = 1'b0;

        // Asynchronous reset in the middle of tile B
        #3 rst_n = 1'b0;
        #1;
        check("t1_async_aout", ifa.Aout, 32'h0);
        check("t1_async_valid", ifa.out_valid, 1'b0);
        check("t1_async_busy", ifa.busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_release_wr_ready", ifa.wr_ready, 1'b1);
        check("t1_release_busy", ifa.busy, 1'b0);
        tick();
        check("t1_no_restart_busy", ifa.busy, 1'b0);
        check("t1_no_restart_valid", ifa.out_valid, 1'b0);

        // Unskewed instance: 4-step drain, then clr during a transposed drain
        ifb.mode = 1'b0;
        load_b(0);
        tick();
        check("t6_busy", ifb.busy, 1'b1);
        for (int s = 0; s <= 3; s++) begin
            tick();
            check($sformatf("t6_valid_s%0d", s), ifb.out_valid, 1'b1);
            check($sformatf("t6_aout_s%0d", s), ifb.Aout, exp_aout(0, 1'b0, 1'b0, s));
            check($sformatf("t6_done_s%0d", s), ifb.tile_done, (s == 3) ? 1'b1 : 1'b0);
            if (s == 0) check("t6_step0_literal", ifb.Aout, 32'h3020_1000);
        end
        tick();
        check("t6_idle_valid", ifb.out_valid, 1'b0);
        check("t6_idle_busy", ifb.busy, 1'b0);

        ifb.mode = 1'b1;
        load_b(0);
        tick();
        for (int s = 0; s <= 1; s++) begin
            tick();
            check($sformatf("t6t_aout_s%0d", s), ifb.Aout, exp_aout(0, 1'b1, 1'b0, s));
            if (s == 0) check("t6t_step0_literal", ifb.Aout, 32'h0302_0100);
        end
        ifb.clr = 1'b1;
        tick();
        ifb.clr = 1'b0;
        check("t6_clr_valid", ifb.out_valid, 1'b0);
        check("t6_clr_busy", ifb.busy, 1'b0);
        check("t6_clr_done", ifb.tile_done, 1'b0);
        check("t6_clr_wr_ready", ifb.wr_ready, 1'b1);
        check("t6_clr_aout", ifb.Aout, 32'h0);
        tick();
        tick();
        check("t6_clr_stays_idle", ifb.busy, 1'b0);
        check("t6_clr_no_output", ifb.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
